// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, error causes, latency bound
// and the request classifier used by the top level.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_EMPTY_BE = 2'd3
  } err_e;

  localparam int LATENCY_MAX = 15;

  // Priority: misaligned > out of range > store with no lanes enabled.
  function automatic err_e classify(input logic [1:0]  byte_lsb,
                                    input logic        below_base,
                                    input logic [29:0] word_off,
                                    input int          depth,
                                    input logic        we,
                                    input logic [3:0]  be);
    err_e e;
    e = ERR_NONE;
    if (byte_lsb != 2'b00)                     e = ERR_MISALIGN;
    else if (below_base || word_off >= 30'(depth)) e = ERR_RANGE;
    else if (we && be == 4'b0000)              e = ERR_EMPTY_BE;
    return e;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed 32-bit storage, single port: per-byte synchronous write, combinational read.
// Contents are never reset.
module data_mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [3:0]    lane_we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits LATENCY cycles, then emits one response beat.
// Response has no backpressure; req_ready is low while a request is in its wait phase.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT4     = LATENCY[3:0];

  if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("data_mem_responder: LATENCY %0d outside 0..%0d", LATENCY, LATENCY_MAX);
  end

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [3:0]  cur_be;
  logic [31:0] cur_wdata;
  logic [32:0] byte_off;
  err_e        cur_err;
  logic        wr_en;
  logic [31:0] rd_data;

  assign accept = req_valid && ready_q;

  // With zero latency the commit edge is the accept edge, so the live request is used directly.
  assign enter_resp = ZERO_LAT ? accept : (state_q == ST_WAIT && cnt_q == 4'd0);
  assign cur_we     = ZERO_LAT ? req_we    : we_q;
  assign cur_addr   = ZERO_LAT ? req_addr  : addr_q;
  assign cur_be     = ZERO_LAT ? req_be    : be_q;
  assign cur_wdata  = ZERO_LAT ? req_wdata : wdata_q;

  assign byte_off = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign cur_err  = classify(byte_off[1:0], byte_off[32], byte_off[31:2],
                             DEPTH_WORDS, cur_we, cur_be);
  assign wr_en    = reset && enter_resp && cur_we && (cur_err == ERR_NONE);

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i     (clk),
    .lane_we_i ({4{wr_en}} & cur_be),
    .addr_i    (byte_off[AW+1:2]),
    .wdata_i   (cur_wdata),
    .rdata_o   (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= enter_resp;
      resp_err_q   <= enter_resp && (cur_err != ERR_NONE);
      resp_rdata_q <= (enter_resp && !cur_we && cur_err == ERR_NONE) ? rd_data : 32'd0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            if (ZERO_LAT) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= LAT4 - 4'd1;
              ready_q <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2, BASE_ADDR=0).
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (2),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request, returns response data/err and the number of edges from accept to resp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input string tag,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    req_we = we; req_addr = addr; req_be = be; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    step();
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    lat = 0;
    rd = 32'hx;
    er = 1'bx;
    do begin
      step();
      lat++;
    end while (!resp_valid && lat < 20);
    rd = resp_rdata;
    er = resp_err;
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    step();
    chk({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        was_rdy;
  logic        bb_we    [4];
  logic [31:0] bb_addr  [4];
  logic [3:0]  bb_be    [4];
  logic [31:0] bb_wdata [4];
  logic [31:0] bb_exp   [4];
  int          acc_at   [4];
  int          resp_at  [4];
  logic [31:0] resp_d   [4];
  int          acc_n;
  int          resp_n;
  int          stray;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'd0; req_be = 4'd0; req_wdata = 32'd0;
    step();
    step();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    reset = 1'b1;
    step();
    chk("ready_after_release", {31'd0, req_ready}, 32'd1);

    do_req(1'b1, 32'h0, 4'hF, 32'h1111_1111, "st0", rd, er, lat);
    chk("st0_err", {31'd0, er}, 32'd0);
    do_req(1'b1, 32'h10, 4'hF, 32'h2222_2000, "st10", rd, er, lat);
    chk("st10_err", {31'd0, er}, 32'd0);
    chk("st10_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, "ld10", rd, er, lat);
    chk("ld10_rdata", rd, 32'h2222_2000);
    chk("ld10_err", {31'd0, er}, 32'd0);

    do_req(1'b1, 32'h10, 4'b0001, 32'h0000_00AB, "st10_b0", rd, er, lat);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, "ld10_b", rd, er, lat);
    chk("ld10_b_rdata", rd, 32'h2222_20AB);

    do_req(1'b0, 32'h12, 4'h0, 32'h0, "ld_mis", rd, er, lat);
    chk("ld_mis_err", {31'd0, er}, 32'd1);
    chk("ld_mis_rdata", rd, 32'd0);
    do_req(1'b0, 32'h400, 4'h0, 32'h0, "ld_oor", rd, er, lat);
    chk("ld_oor_err", {31'd0, er}, 32'd1);
    chk("ld_oor_rdata", rd, 32'd0);

    do_req(1'b1, 32'h12, 4'hF, 32'hFFFF_FFFF, "st_mis", rd, er, lat);
    chk("st_mis_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 32'h400, 4'hF, 32'hDEAD_BEEF, "st_oor", rd, er, lat);
    chk("st_oor_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, "st_nobe", rd, er, lat);
    chk("st_nobe_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, "ld10_keep", rd, er, lat);
    chk("ld10_keep_rdata", rd, 32'h2222_20AB);
    do_req(1'b0, 32'h0, 4'h0, 32'h0, "ld0_keep", rd, er, lat);
    chk("ld0_keep_rdata", rd, 32'h1111_1111);

    // Four requests with req_valid held high.
    bb_we    = '{1'b1, 1'b0, 1'b1, 1'b0};
    bb_addr  = '{32'h30, 32'h30, 32'h30, 32'h30};
    bb_be    = '{4'hF, 4'h0, 4'b1100, 4'h0};
    bb_wdata = '{32'hA5A5_A5A5, 32'h0, 32'h1234_0000, 32'h0};
    bb_exp   = '{32'h0, 32'hA5A5_A5A5, 32'h0, 32'h1234_A5A5};
    acc_n = 0;
    resp_n = 0;
    req_we = bb_we[0]; req_addr = bb_addr[0]; req_be = bb_be[0]; req_wdata = bb_wdata[0];
    req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      was_rdy = req_ready;
      step();
      if (was_rdy && req_valid) begin
        if (acc_n < 4) acc_at[acc_n] = i;
        acc_n++;
        if (acc_n < 4) begin
          req_we = bb_we[acc_n]; req_addr = bb_addr[acc_n];
          req_be = bb_be[acc_n]; req_wdata = bb_wdata[acc_n];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (resp_valid) begin
        if (resp_n < 4) begin
          resp_d[resp_n]  = resp_rdata;
          resp_at[resp_n] = i;
        end
        resp_n++;
      end
    end
    chk("bb_accepts", 32'(acc_n), 32'd4);
    chk("bb_resps", 32'(resp_n), 32'd4);
    if (acc_n == 4 && resp_n == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("bb_acc_at%0d", k), 32'(acc_at[k]), 32'(3 * k));
        chk($sformatf("bb_resp_at%0d", k), 32'(resp_at[k]), 32'(3 * k + 2));
        chk($sformatf("bb_rdata%0d", k), resp_d[k], bb_exp[k]);
      end
    end

    // Reset during WAIT drops the pending store.
    do_req(1'b1, 32'h20, 4'hF, 32'h0000_0077, "st20", rd, er, lat);
    req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h0000_0005;
    req_valid = 1'b1;
    chk("pre_abort_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    step();
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (resp_valid) stray++;
    end
    chk("abort_no_resp", 32'(stray), 32'd0);
    do_req(1'b0, 32'h20, 4'h0, 32'h0, "ld20", rd, er, lat);
    chk("ld20_rdata", rd, 32'h0000_0077);
    chk("ld20_err", {31'd0, er}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
